// File: rtl/retire_trace_port.sv
// Retirement trace port: captures CPU writeback records into a FIFO and
// streams them to a checker over a valid/ready channel, with halt-driven drain.
module retire_trace_port #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [31:0]      wb_inst,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  input  logic             halt_in,
  output logic             wb_stall,
  output logic             tr_valid,
  input  logic             tr_ready,
  output logic [31:0]      tr_inst,
  output logic [4:0]       tr_rd,
  output logic [31:0]      tr_data,
  output logic [SEQ_W-1:0] tr_seq,
  output logic             overflow,
  output logic             done
);

  // Handshake: a record transfers on any rising edge where tr_valid and
  // tr_ready are both 1; while tr_valid=1 and tr_ready=0 every tr_* output
  // holds. wb_valid is a one-way strobe; wb_stall only advises the CPU.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ALMOST_C = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;

  logic [31:0]      mem_inst_q [DEPTH];
  logic [4:0]       mem_rd_q   [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];
  logic [SEQ_W-1:0] mem_seq_q  [DEPTH];

  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic [4:0]  rec_rd;
  logic [31:0] rec_data;

  // Outputs are gated by rst so they read 0 while reset is held, even
  // before the first clock edge has cleared the registers.
  assign tr_valid = rst && (count_q != '0);
  assign wb_stall = rst && (count_q >= ALMOST_C);
  assign done     = rst && (state_q == ST_DONE);
  assign overflow = overflow_q;

  assign tr_inst = mem_inst_q[rd_ptr_q];
  assign tr_rd   = mem_rd_q[rd_ptr_q];
  assign tr_data = mem_data_q[rd_ptr_q];
  assign tr_seq  = mem_seq_q[rd_ptr_q];

  assign push_req = wb_valid && (state_q == ST_RUN);
  assign push_ok  = push_req && (count_q != FULL_C);
  assign pop      = tr_valid && tr_ready;

  // Writes to x0 carry no architectural result, so they are reported as zero.
  assign rec_rd   = wb_we ? wb_rd : 5'd0;
  assign rec_data = (wb_we && (wb_rd != 5'd0)) ? wb_data : 32'd0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      seq_d    = seq_q + SEQ_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (halt_in) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((count_q == '0) || ((count_q == (AW+1)'(1)) && pop)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: it is only observed through a valid count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_inst_q[wr_ptr_q] <= wb_inst;
      mem_rd_q[wr_ptr_q]   <= rec_rd;
      mem_data_q[wr_ptr_q] <= rec_data;
      mem_seq_q[wr_ptr_q]  <= seq_q;
    end
  end

endmodule

// File: tb/tb_retire_trace_port.sv
// Directed plus randomized bench for retire_trace_port, checked against a
// queue-based reference model of the retirement trace behaviour.
module tb_retire_trace_port;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 4;

  logic             clk;
  logic             rst;
  logic             wb_valid;
  logic [31:0]      wb_inst;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             halt_in;
  logic             wb_stall;
  logic             tr_valid;
  logic             tr_ready;
  logic [31:0]      tr_inst;
  logic [4:0]       tr_rd;
  logic [31:0]      tr_data;
  logic [SEQ_W-1:0] tr_seq;
  logic             overflow;
  logic             done;

  retire_trace_port #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_inst  (wb_inst),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .halt_in  (halt_in),
    .wb_stall (wb_stall),
    .tr_valid (tr_valid),
    .tr_ready (tr_ready),
    .tr_inst  (tr_inst),
    .tr_rd    (tr_rd),
    .tr_data  (tr_data),
    .tr_seq   (tr_seq),
    .overflow (overflow),
    .done     (done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0]      inst;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic [SEQ_W-1:0] seq;
  } rec_t;

  rec_t exp_q[$];
  int   m_seq;
  bit   m_ovf;
  int   m_mode;   // 0 = running, 1 = draining after halt, 2 = finished
  int   n_assert;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    if (!rst) begin
      chk("rst_tr_valid", {31'd0, tr_valid}, 32'd0);
      chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
    end else begin
      chk("tr_valid", {31'd0, tr_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        chk("tr_inst", tr_inst, exp_q[0].inst);
        chk("tr_rd", {27'd0, tr_rd}, {27'd0, exp_q[0].rd});
        chk("tr_data", tr_data, exp_q[0].data);
        chk("tr_seq", {28'd0, tr_seq}, {28'd0, exp_q[0].seq});
      end
      chk("wb_stall", {31'd0, wb_stall}, {31'd0, exp_q.size() >= DEPTH - 1});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("done", {31'd0, done}, {31'd0, m_mode == 2});
    end
  endtask

  task automatic model_update();
    int   start;
    bit   pop;
    bit   push;
    rec_t r;
    if (!rst) begin
      exp_q.delete();
      m_seq  = 0;
      m_ovf  = 1'b0;
      m_mode = 0;
      return;
    end
    start = exp_q.size();
    pop   = (start > 0) && tr_ready;
    push  = wb_valid && (m_mode == 0);
    if (m_mode == 0 && halt_in) m_mode = 1;
    else if (m_mode == 1 && (start == 0 || (start == 1 && pop))) m_mode = 2;
    if (pop) void'(exp_q.pop_front());
    if (push && start == DEPTH) m_ovf = 1'b1;
    if (push && start < DEPTH) begin
      r.inst = wb_inst;
      r.rd   = wb_we ? wb_rd : 5'd0;
      r.data = (wb_we && wb_rd != 5'd0) ? wb_data : 32'd0;
      r.seq  = SEQ_W'(m_seq);
      exp_q.push_back(r);
      m_seq = (m_seq + 1) % (1 << SEQ_W);
    end
  endtask

  // One clock: check outputs mid-cycle, advance model, settle after edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    wb_valid = 1'b0;
    halt_in  = 1'b0;
  endtask

  task automatic drive_wb(input logic [31:0] inst, input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
    wb_valid = 1'b1;
    wb_inst  = inst;
    wb_we    = we;
    wb_rd    = rd;
    wb_data  = data;
  endtask

  task automatic drive_rand();
    drive_wb($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    idle();
    repeat (cycles) cycle();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    n_assert = 0;
    n_fail   = 0;
    m_seq    = 0;
    m_ovf    = 1'b0;
    m_mode   = 0;
    rst      = 1'b0;
    tr_ready = 1'b0;
    wb_inst  = '0;
    wb_we    = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    idle();

    // Reset and the cycle after release.
    do_reset(2);
    chk("post_rst_overflow", {31'd0, overflow}, 32'd0);
    cycle();

    // Basic flow: ADDI x1, x0, 5.
    tr_ready = 1'b1;
    drive_wb(32'h0050_0093, 1'b1, 5'd1, 32'd5);
    cycle();
    idle();
    chk("basic_valid", {31'd0, tr_valid}, 32'd1);
    chk("basic_rd", {27'd0, tr_rd}, 32'd1);
    chk("basic_data", tr_data, 32'd5);
    chk("basic_seq", {28'd0, tr_seq}, 32'd0);
    cycle();

    // Normalisation: write to x0, then a non-writing instruction.
    tr_ready = 1'b0;
    drive_wb(32'h0000_0013, 1'b1, 5'd0, 32'h1234);
    cycle();
    drive_wb(32'h0000_7063, 1'b0, 5'd7, 32'hdead_beef);
    cycle();
    idle();
    chk("norm_rd0", {27'd0, tr_rd}, 32'd0);
    chk("norm_data0", tr_data, 32'd0);
    tr_ready = 1'b1;
    cycle();
    chk("norm_rd1", {27'd0, tr_rd}, 32'd0);
    chk("norm_data1", tr_data, 32'd0);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) drive_rand();
      else wb_valid = 1'b0;
      tr_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    idle();
    tr_ready = 1'b1;
    repeat (DEPTH + 1) cycle();

    // Backpressure: fill to DEPTH, then one dropped push.
    do_reset(1);
    cycle();
    tr_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_wb(32'h100 + 32'(i), 1'b1, 5'(i + 1), 32'(i * 3));
      cycle();
      if (i == DEPTH - 2) chk("bp_stall_at_7", {31'd0, wb_stall}, 32'd1);
    end
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    chk("bp_head_seq", {28'd0, tr_seq}, 32'd0);
    // Simultaneous push and pop while full.
    tr_ready = 1'b1;
    drive_rand();
    cycle();
    idle();
    chk("full_pushpop_seq", {28'd0, tr_seq}, 32'd1);
    repeat (DEPTH) cycle();
    chk("bp_empty", {31'd0, tr_valid}, 32'd0);

    // Sequence wrap with SEQ_W = 4.
    do_reset(1);
    cycle();
    tr_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_rand();
      cycle();
    end
    idle();
    chk("wrap_seq", {28'd0, tr_seq}, 32'd0);
    cycle();

    // Reset mid-operation with five records buffered.
    tr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      cycle();
    end
    do_reset(1);
    chk("midrst_valid", {31'd0, tr_valid}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    cycle();
    drive_rand();
    cycle();
    idle();
    chk("midrst_seq", {28'd0, tr_seq}, 32'd0);
    tr_ready = 1'b1;
    cycle();

    // Halt: three buffered, halt with a push in the same cycle.
    do_reset(1);
    cycle();
    tr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      cycle();
    end
    drive_rand();
    halt_in = 1'b1;
    cycle();
    idle();
    chk("halt_count4_seq", {28'd0, tr_seq}, 32'd0);
    cycle();
    tr_ready = 1'b1;
    budget = 20;
    while (!done && budget > 0) begin
      if ($urandom_range(0, 3) == 0) tr_ready = 1'b0;
      else tr_ready = 1'b1;
      cycle();
      budget--;
    end
    chk("halt_done_reached", {31'd0, done}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      cycle();
    end
    idle();
    chk("done_ignores_wb", {31'd0, tr_valid}, 32'd0);
    chk("done_sticky", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
